// File: rtl/register_file_if.sv
// ----------------------------------------------------------------------------
// register_file_if
// Bundle between the CPU32 writeback / operand-fetch stages and the register
// file.
//   write[1:0]      per-port write strobe (bit0 = port 1, bit1 = port 2)
//   wr1, wr2        write data, ports 1 and 2
//   wa1, wa2        write addresses, ports 1 and 2
//   re1, re2        read enables
//   ra1, ra2        read addresses
//   rd1, rd2        registered read data
//   rv1, rv2        read-valid, high the cycle after an accepted read
//   wconf           one-cycle flag after a same-address dual write
// Modports: master = pipeline side, slave = register file.
// ----------------------------------------------------------------------------
interface register_file_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       write;
    logic [WIDTH-1:0] wr1;
    logic [WIDTH-1:0] wr2;
    logic [4:0]       wa1;
    logic [4:0]       wa2;
    logic             re1;
    logic             re2;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             rv1;
    logic             rv2;
    logic             wconf;

    modport master (
        output write, wr1, wr2, wa1, wa2, re1, re2, ra1, ra2,
        input  rd1, rd2, rv1, rv2, wconf
    );

    modport slave (
        input  write, wr1, wr2, wa1, wa2, re1, re2, ra1, ra2,
        output rd1, rd2, rv1, rv2, wconf
    );
endinterface

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// Dual-write, dual-read DEPTH x WIDTH register file for the CPU32 core.
// Write side takes the writeback bundle (write/wr1/wr2/wa1/wa2); port 2 wins
// when both ports write the same address. Read side has two independently
// enabled, registered read ports with same-edge write-through forwarding.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   register_file_if.slave (write, wr1, wr2, wa1, wa2, re1, re2,
//         ra1, ra2 in; rd1, rd2, rv1, rv2, wconf out)
//
// Configuration macro: REGISTER_FILE_ZERO_REG_EN
//   defined   -> register 0 reads as 0, writes to it are dropped and never
//                forwarded (a dual write to 0 still raises wconf)
//   undefined -> register 0 is ordinary storage
// ----------------------------------------------------------------------------
module register_file #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    register_file_if.slave        bus
);

    // Address space is fixed at 5 bits; DEPTH may be smaller than 32.
    localparam logic [5:0] DEPTH_LIM = 6'(DEPTH);

`ifdef REGISTER_FILE_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic             we1_s;
    logic             we2_s;
    logic             conf_s;
    logic [WIDTH-1:0] rd1_nxt_s;
    logic [WIDTH-1:0] rd2_nxt_s;

    // An address is backed by storage if it is below DEPTH and is not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [4:0] a);
        return ({1'b0, a} < DEPTH_LIM) && !(ZERO_REG && (a == 5'd0));
    endfunction

    // Value of a register as it will be after this edge's writes:
    // port 2 write first, then port 1 write, then stored data.
    function automatic logic [WIDTH-1:0] fwd_read(input logic [4:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!addr_ok(a)) begin
            v = '0;
        end else if (we2_s && (bus.wa2 == a)) begin
            v = bus.wr2;
        end else if (we1_s && (bus.wa1 == a)) begin
            v = bus.wr1;
        end else begin
            v = regs_r[a];
        end
        return v;
    endfunction

    // Qualified write enables and same-address dual write detection.
    always_comb begin
        we1_s  = 1'b0;
        we2_s  = 1'b0;
        conf_s = 1'b0;
        if (bus.write[0]) begin
            we1_s = addr_ok(bus.wa1);
        end else begin
            we1_s = 1'b0;
        end
        if (bus.write[1]) begin
            we2_s = addr_ok(bus.wa2);
        end else begin
            we2_s = 1'b0;
        end
        // The conflict flag ignores address qualification on purpose: a
        // dual write to the zero register still reports a conflict.
        if ((bus.write == 2'b11) && (bus.wa1 == bus.wa2)) begin
            conf_s = 1'b1;
        end else begin
            conf_s = 1'b0;
        end
    end

    // Next read data for both ports, with write-through forwarding.
    always_comb begin
        rd1_nxt_s = '0;
        rd2_nxt_s = '0;
        rd1_nxt_s = fwd_read(bus.ra1);
        rd2_nxt_s = fwd_read(bus.ra2);
    end

    // Register storage; port 2 is written last so it wins a conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (we1_s) begin
                regs_r[bus.wa1] <= bus.wr1;
            end
            if (we2_s) begin
                regs_r[bus.wa2] <= bus.wr2;
            end
        end
    end

    // Registered read ports and conflict flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd1   <= '0;
            bus.rd2   <= '0;
            bus.rv1   <= 1'b0;
            bus.rv2   <= 1'b0;
            bus.wconf <= 1'b0;
        end else begin
            bus.wconf <= conf_s;
            bus.rv1   <= bus.re1;
            bus.rv2   <= bus.re2;
            if (bus.re1) begin
                bus.rd1 <= rd1_nxt_s;
            end
            if (bus.re2) begin
                bus.rd2 <= rd2_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
// Directed steps from the register_file test plan followed by randomized
// traffic, checked against an array-based reference model of the register
// file behaviour. Honours REGISTER_FILE_ZERO_REG_EN like the design.
// ----------------------------------------------------------------------------
module tb_register_file;

    logic clk;
    logic rst;

    register_file_if #(.WIDTH(32)) bus ();

    register_file #(.DEPTH(32), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef REGISTER_FILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] e_rd1, e_rd2;
    logic        e_rv1, e_rv2, e_wconf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd1"},   bus.rd1,          e_rd1);
        check({tag, ".rd2"},   bus.rd2,          e_rd2);
        check({tag, ".rv1"},   {31'd0, bus.rv1}, {31'd0, e_rv1});
        check({tag, ".rv2"},   {31'd0, bus.rv2}, {31'd0, e_rv2});
        check({tag, ".wconf"}, {31'd0, bus.wconf}, {31'd0, e_wconf});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        e_rd1 = 32'd0; e_rd2 = 32'd0;
        e_rv1 = 1'b0;  e_rv2 = 1'b0;  e_wconf = 1'b0;
    endtask

    // Apply the current inputs to the model (writes first, then reads see
    // the updated array), clock the DUT and compare every output.
    task automatic do_cycle(input string tag);
        if (bus.write[0] && !(ZERO_EN && bus.wa1 == 5'd0)) m_regs[bus.wa1] = bus.wr1;
        if (bus.write[1] && !(ZERO_EN && bus.wa2 == 5'd0)) m_regs[bus.wa2] = bus.wr2;
        e_wconf = (bus.write == 2'b11) && (bus.wa1 == bus.wa2);
        e_rv1 = bus.re1;
        e_rv2 = bus.re2;
        if (bus.re1) e_rd1 = m_regs[bus.ra1];
        if (bus.re2) e_rd2 = m_regs[bus.ra2];
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_idle();
        bus.write = 2'b00;
        bus.wr1 = 32'd0; bus.wr2 = 32'd0;
        bus.wa1 = 5'd0;  bus.wa2 = 5'd0;
        bus.re1 = 1'b0;  bus.re2 = 1'b0;
        bus.ra1 = 5'd0;  bus.ra2 = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();

        // Reset asserted between edges: outputs clear without a clock
        #2 rst = 1'b0;
        #1 check_all("reset");

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Read after reset
        bus.re1 = 1'b1; bus.ra1 = 5'd7;
        do_cycle("read_after_reset");
        check("read_after_reset.rd1_is_zero", bus.rd1, 32'd0);

        // Single write, then read on the next edge
        set_idle();
        bus.write = 2'b01; bus.wa1 = 5'd3; bus.wr1 = 32'hDEADBEEF;
        do_cycle("single_write");
        set_idle();
        bus.re2 = 1'b1; bus.ra2 = 5'd3;
        do_cycle("read_stored");
        check("read_stored.rd2_value", bus.rd2, 32'hDEADBEEF);

        // Cross forwarding on a dual write
        set_idle();
        bus.write = 2'b11;
        bus.wa1 = 5'd5; bus.wr1 = 32'h11;
        bus.wa2 = 5'd6; bus.wr2 = 32'h22;
        bus.re1 = 1'b1; bus.ra1 = 5'd6;
        bus.re2 = 1'b1; bus.ra2 = 5'd5;
        do_cycle("forward");
        check("forward.rd1_value", bus.rd1, 32'h22);
        check("forward.rd2_value", bus.rd2, 32'h11);

        // Write conflict: port 2 wins, wconf for exactly one cycle
        set_idle();
        bus.write = 2'b11;
        bus.wa1 = 5'd9; bus.wr1 = 32'hAAAA;
        bus.wa2 = 5'd9; bus.wr2 = 32'h5555;
        bus.re1 = 1'b1; bus.ra1 = 5'd9;
        do_cycle("conflict");
        check("conflict.wconf_high", {31'd0, bus.wconf}, 32'd1);
        check("conflict.rd1_fwd", bus.rd1, 32'h5555);
        set_idle();
        bus.re2 = 1'b1; bus.ra2 = 5'd9;
        do_cycle("conflict_after");
        check("conflict_after.wconf_low", {31'd0, bus.wconf}, 32'd0);
        check("conflict_after.rd2_value", bus.rd2, 32'h5555);

        // Zero register write then read (also with same-edge forwarding)
        set_idle();
        bus.write = 2'b01; bus.wa1 = 5'd0; bus.wr1 = 32'h1234;
        bus.re2 = 1'b1; bus.ra2 = 5'd0;
        do_cycle("zero_write");
        set_idle();
        bus.re1 = 1'b1; bus.ra1 = 5'd0;
        do_cycle("zero_read");
        check("zero_read.rd1_value", bus.rd1, ZERO_EN ? 32'd0 : 32'h1234);

        // Dual write to address 0 still raises wconf
        set_idle();
        bus.write = 2'b11; bus.wa1 = 5'd0; bus.wa2 = 5'd0;
        bus.wr1 = 32'h77; bus.wr2 = 32'h88;
        do_cycle("zero_conflict");

        // Randomized traffic, small address window half the time for hits
        for (int n = 0; n < 400; n++) begin
            bus.write = 2'($urandom_range(0, 3));
            bus.wr1 = $urandom;
            bus.wr2 = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                bus.wa1 = 5'($urandom_range(0, 3));
                bus.wa2 = 5'($urandom_range(0, 3));
                bus.ra1 = 5'($urandom_range(0, 3));
                bus.ra2 = 5'($urandom_range(0, 3));
            end else begin
                bus.wa1 = 5'($urandom_range(0, 31));
                bus.wa2 = 5'($urandom_range(0, 31));
                bus.ra1 = 5'($urandom_range(0, 31));
                bus.ra2 = 5'($urandom_range(0, 31));
            end
            bus.re1 = 1'($urandom_range(0, 1));
            bus.re2 = 1'($urandom_range(0, 1));
            do_cycle("random");
        end

        // Async reset mid-stream
        set_idle();
        bus.write = 2'b01; bus.wa1 = 5'd4; bus.wr1 = 32'hFFFFFFFF;
        bus.re1 = 1'b1; bus.ra1 = 5'd4;
        bus.re2 = 1'b1; bus.ra2 = 5'd4;
        do_cycle("pre_reset");
        check("pre_reset.rd1_value", bus.rd1, 32'hFFFFFFFF);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        bus.re1 = 1'b1; bus.ra1 = 5'd4;
        bus.re2 = 1'b1; bus.ra2 = 5'd4;
        do_cycle("post_reset");
        check("post_reset.rd1_zero", bus.rd1, 32'd0);

        set_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
